// File: rtl/ei_pkg.sv
// Shared definitions for the 802.15.4 chip spreader:
// PN chip table, FSM state type and sequence length.
package ei_pkg;

    localparam int CHIP_LEN = 32;
    localparam int NUM_SYM  = 16;
    localparam int PRE_W    = 8;
    localparam int K_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SPREAD
    } ei_state_t;

    // Bit 31 holds c[0]; chips are sent MSB first.
    localparam logic [CHIP_LEN-1:0] CHIP_TBL [NUM_SYM] = '{
        32'hD9C3522E,
        32'hED9C3522,
        32'h2ED9C352,
        32'h22ED9C35,
        32'h522ED9C3,
        32'h3522ED9C,
        32'hC3522ED9,
        32'h9C3522ED,
        32'h8C96077B,
        32'hB8C96077,
        32'h7B8C9607,
        32'h77B8C960,
        32'h077B8C96,
        32'h6077B8C9,
        32'h96077B8C,
        32'hC96077B8
    };

    function automatic logic [CHIP_LEN-1:0] chip_seq(
        input logic [3:0] sym
    );
        return CHIP_TBL[sym];
    endfunction

endpackage

// File: rtl/ei_sync_fifo.sv
// Symbol FIFO between the CPU write port and the spreader FSM.
// Occupancy is tracked with one extra bit so full and empty never alias.
module ei_sync_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  do_pop;
    logic                  accept;

    assign full   = (cnt == (ADDR_WIDTH+1)'(DEPTH));
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign data   = mem[rptr];
    assign do_pop = pop && !empty;
    // A full FIFO still takes a write when a slot frees up this clock.
    assign accept = write && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (accept) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({accept, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr] <= din;
        end
    end

endmodule

// File: rtl/ei_chip_spreader.sv
// O-QPSK chip spreader: FIFO'd 4-bit symbols to 32-chip PN I/Q streams.
// Define EI_STATUS_EN to add overflow/level status ports.
module ei_chip_spreader
    import ei_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int CHIP_DIV   = 4
) (
    input  logic                  inClock,
    input  logic                  inReset,
    input  logic                  inWriteEnable,
    input  logic [DATA_WIDTH-1:0] inCPUdata,
    output logic                  o_chipI,
    output logic                  o_chipQ,
    output logic                  o_chipStrobe,
    output logic                  o_busy,
    output logic                  o_full,
    output logic                  o_empty
`ifdef EI_STATUS_EN
    ,
    input  logic                  inErrClear,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_level
`endif
);

    if (DATA_WIDTH != 4) begin : g_dw_chk
        $error("ei_chip_spreader: DATA_WIDTH must be 4");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 6) begin : g_aw_chk
        $error("ei_chip_spreader: ADDR_WIDTH must be 1..6");
    end
    if (CHIP_DIV < 1 || CHIP_DIV > 255) begin : g_div_chk
        $error("ei_chip_spreader: CHIP_DIV must be 1..255");
    end

    ei_state_t             state;
    ei_state_t             state_n;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [ADDR_WIDTH:0]   count;
    logic                  has_data;
    logic                  pop;
    logic                  load;
    logic                  adv;
    logic                  stop;
    logic                  last_tick;
    logic                  last_chip;
    logic [CHIP_LEN-1:0]   seq;
    logic [CHIP_LEN-1:0]   nseq;
    logic [K_W-1:0]        k;
    logic [PRE_W-1:0]      pres;

    ei_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
        .clk  (inClock),
        .rst  (inReset),
        .write(inWriteEnable),
        .din  (inCPUdata),
        .pop  (pop),
        .data (fifo_data),
        .full (o_full),
        .empty(o_empty),
        .count(count)
    );

    assign has_data  = (count != '0);
    assign last_tick = (pres == PRE_W'(CHIP_DIV - 1));
    assign last_chip = (k == K_W'(CHIP_LEN - 1));
    assign nseq      = chip_seq(fifo_data[3:0]);
    assign o_busy    = (state != ST_IDLE);

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        load    = 1'b0;
        adv     = 1'b0;
        stop    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (has_data) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pop     = 1'b1;
                load    = 1'b1;
                state_n = ST_SPREAD;
            end
            ST_SPREAD: begin
                if (last_tick) begin
                    if (!last_chip) begin
                        adv = 1'b1;
                    end else if (has_data) begin
                        // Chain straight into the next symbol.
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        stop    = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // seq is pre-shifted so seq[31] is always the next chip to send.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            seq          <= '0;
            k            <= '0;
            pres         <= '0;
            o_chipI      <= 1'b0;
            o_chipQ      <= 1'b0;
            o_chipStrobe <= 1'b0;
        end else begin
            unique case (1'b1)
                load: begin
                    seq          <= nseq << 1;
                    o_chipI      <= nseq[CHIP_LEN-1];
                    o_chipStrobe <= 1'b1;
                    k            <= '0;
                    pres         <= '0;
                end
                adv: begin
                    if (k[0]) begin
                        o_chipI <= seq[CHIP_LEN-1];
                    end else begin
                        o_chipQ <= seq[CHIP_LEN-1];
                    end
                    seq          <= seq << 1;
                    o_chipStrobe <= 1'b1;
                    k            <= k + 1'b1;
                    pres         <= '0;
                end
                stop: begin
                    o_chipI      <= 1'b0;
                    o_chipQ      <= 1'b0;
                    o_chipStrobe <= 1'b0;
                    k            <= '0;
                    pres         <= '0;
                end
                default: begin
                    o_chipStrobe <= 1'b0;
                    if (state == ST_SPREAD) begin
                        pres <= pres + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef EI_STATUS_EN
    logic dropped;

    assign dropped = inWriteEnable && o_full && !pop;
    assign o_level = count;

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            o_overflow <= 1'b0;
        end else if (dropped) begin
            o_overflow <= 1'b1;
        end else if (inErrClear) begin
            o_overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ei_chip_spreader.sv
// Bench for ei_chip_spreader: directed scenarios plus random writes,
// checked against a symbol-queue timeline model.
module tb_ei_chip_spreader;

    localparam int DIV    = 4;
    localparam int DEPTH  = 4;
    localparam int SYMLEN = 32 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we_a = 1'b0;
    logic [3:0] data_a = 4'h0;
    logic       we_b = 1'b0;
    logic [3:0] data_b = 4'h0;

    logic ia, qa, sa, ba, fa, ea;
    logic ib, qb, sb, bb, fb, eb;

    ei_chip_spreader #(
        .DATA_WIDTH(4),
        .ADDR_WIDTH(2),
        .CHIP_DIV  (DIV)
    ) dut_a (
        .inClock      (clk),
        .inReset      (rst),
        .inWriteEnable(we_a),
        .inCPUdata    (data_a),
        .o_chipI      (ia),
        .o_chipQ      (qa),
        .o_chipStrobe (sa),
        .o_busy       (ba),
        .o_full       (fa),
        .o_empty      (ea)
    );

    ei_chip_spreader #(
        .DATA_WIDTH(4),
        .ADDR_WIDTH(2),
        .CHIP_DIV  (1)
    ) dut_b (
        .inClock      (clk),
        .inReset      (rst),
        .inWriteEnable(we_b),
        .inCPUdata    (data_b),
        .o_chipI      (ib),
        .o_chipQ      (qb),
        .o_chipStrobe (sb),
        .o_busy       (bb),
        .o_full       (fb),
        .o_empty      (eb)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Symbol 0 PN sequence, c[0] in bit 31.
    logic [31:0] s0 = 32'b11011001110000110101001000101110;

    // Symbols 1..7 rotate symbol 0 by 4 chips each; 8..15 also invert odd chips.
    function automatic logic chip(int sym, int j);
        int   idx;
        logic b;
        idx = (j - 4 * (sym % 8) + 64) % 32;
        b   = s0[31-idx];
        if (sym >= 8 && (j % 2) == 1) b = ~b;
        return b;
    endfunction

    int   m_phase;
    int   m_pos;
    int   m_cur;
    logic m_prevq;
    int   q[$];
    int   strobe_cnt;
    int   busy_cnt;

    task automatic check(string tag, logic obs, logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pos   = 0;
        m_cur   = 0;
        m_prevq = 1'b0;
        q.delete();
    endtask

    task automatic model_edge();
        int sz;
        bit popd;
        if (rst) begin
            model_reset();
            return;
        end
        sz   = q.size();
        popd = 0;
        case (m_phase)
            0: if (sz > 0) m_phase = 1;
            1: begin
                m_cur   = q.pop_front();
                popd    = 1;
                m_phase = 2;
                m_pos   = 0;
                m_prevq = 1'b0;
            end
            default: begin
                if (m_pos == SYMLEN - 1) begin
                    if (sz > 0) begin
                        m_prevq = chip(m_cur, 31);
                        m_cur   = q.pop_front();
                        popd    = 1;
                        m_pos   = 0;
                    end else begin
                        m_phase = 0;
                    end
                end else begin
                    m_pos++;
                end
            end
        endcase
        if (we_a && (sz < DEPTH || popd)) q.push_back(int'(data_a));
    endtask

    task automatic compare_all();
        int   k;
        logic ei, eq, es;
        ei = 1'b0;
        eq = 1'b0;
        es = 1'b0;
        if (m_phase == 2) begin
            k  = m_pos / DIV;
            es = (m_pos % DIV) == 0;
            ei = chip(m_cur, k - (k % 2));
            if (k == 0) eq = m_prevq;
            else eq = chip(m_cur, (k % 2 == 1) ? k : k - 1);
        end
        check("chipI", ia, ei);
        check("chipQ", qa, eq);
        check("strobe", sa, es);
        check("busy", ba, m_phase != 0);
        check("full", fa, q.size() == DEPTH);
        check("empty", ea, q.size() == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (sa) strobe_cnt++;
        if (ba) busy_cnt++;
    endtask

    task automatic write_a(input logic [3:0] sym);
        we_a   = 1'b1;
        data_a = sym;
        tick();
        we_a   = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (ba === 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("drain_done", n < limit, 1'b1);
    endtask

    logic ipat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic qpat[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int n;
        int k;
        int symb;
        logic eqb;

        model_reset();
        strobe_cnt = 0;
        busy_cnt   = 0;
        repeat (3) tick();
        check("rst_empty", ea, 1'b1);
        check("rst_busy", ba, 1'b0);
        rst = 1'b0;
        repeat (2) tick();

        // Single symbol 0: latency, I/Q pattern, spread length.
        write_a(4'h0);
        tick();
        check("lat_load_busy", ba, 1'b1);
        check("lat_load_strobe", sa, 1'b0);
        tick();
        check("lat_strobe", sa, 1'b1);
        check("lat_i", ia, 1'b1);
        n = 0;
        while (ba === 1'b1 && n < 300) begin
            if (n % DIV == 0 && n < 8 * DIV) begin
                k = n / DIV;
                if (k % 2 == 0) check("i_pat", ia, ipat[k/2]);
                else check("q_pat", qa, qpat[k/2]);
            end
            n++;
            tick();
        end
        check_int("spread_len", n, 128);
        repeat (3) tick();

        // Back-to-back symbols must chain without gaps.
        strobe_cnt = 0;
        busy_cnt   = 0;
        write_a(4'hB);
        write_a(4'hF);
        write_a(4'hE);
        write_a(4'h5);
        drain(700);
        check_int("b2b_strobes", strobe_cnt, 128);
        check_int("b2b_busy", busy_cnt, 513);
        repeat (2) tick();

        // Overflow: six writes during one symbol, then a write on the k=31 pop.
        write_a(4'($urandom_range(0, 15)));
        repeat (3) tick();
        for (int i = 0; i < 6; i++) write_a(4'($urandom_range(0, 15)));
        check("ovf_full", fa, 1'b1);
        n = 0;
        while (!(m_phase == 2 && m_pos == SYMLEN - 1) && n < 300) begin
            tick();
            n++;
        end
        check("wait_k31", n < 300, 1'b1);
        write_a(4'($urandom_range(0, 15)));
        check("pop_write_full", fa, 1'b1);
        drain(1000);
        repeat (2) tick();

        // Reset mid-symbol with queued symbols.
        write_a(4'h3);
        write_a(4'h9);
        write_a(4'hC);
        n = 0;
        while (!(m_phase == 2 && m_pos == 10 * DIV) && n < 200) begin
            tick();
            n++;
        end
        check("wait_k10", n < 200, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_mid_empty", ea, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        strobe_cnt = 0;
        repeat (300) tick();
        check_int("post_rst_strobes", strobe_cnt, 0);

        // CHIP_DIV=1 instance: strobe every clock, 32 clocks per symbol.
        symb   = int'($urandom_range(0, 15));
        we_b   = 1'b1;
        data_b = 4'(symb);
        tick();
        we_b = 1'b0;
        tick();
        check("b_load_strobe", sb, 1'b0);
        for (int p = 0; p < 32; p++) begin
            tick();
            eqb = (p == 0) ? 1'b0 : chip(symb, (p % 2 == 1) ? p : p - 1);
            check("b_strobe", sb, 1'b1);
            check("b_busy", bb, 1'b1);
            check("b_chipI", ib, chip(symb, p - (p % 2)));
            check("b_chipQ", qb, eqb);
        end
        tick();
        check("b_idle_busy", bb, 1'b0);
        check("b_idle_strobe", sb, 1'b0);
        check("b_idle_empty", eb, 1'b1);
        check("b_idle_full", fb, 1'b0);

        // Random traffic, including bursts that overrun the FIFO.
        for (int c = 0; c < 4000; c++) begin
            we_a   = ($urandom_range(0, 29) == 0) || (c % 1000 < 8);
            data_a = 4'($urandom_range(0, 15));
            tick();
        end
        we_a = 1'b0;
        drain(1200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
